// File: rtl/audio_stream_bridge_if.sv
// audio_stream_bridge_if: codec FIFO and effects-core stream signals of the audio bridge
interface audio_stream_bridge_if #(
   parameter int SAMPLE_W = 32,
   parameter int NUM_CH   = 2
);
   localparam int FW = SAMPLE_W * NUM_CH;
   logic          audio_in_available;
   logic          read_audio_in;
   logic [FW-1:0] codec_in_data;
   logic          audio_out_allowed;
   logic          write_audio_out;
   logic [FW-1:0] codec_out_data;
   logic          proc_in_valid;
   logic          proc_in_ready;
   logic [FW-1:0] proc_in_data;
   logic          proc_out_valid;
   logic          proc_out_ready;
   logic [FW-1:0] proc_out_data;
   modport master (
      input  audio_in_available, codec_in_data, audio_out_allowed,
             proc_in_ready, proc_out_valid, proc_out_data,
      output read_audio_in, write_audio_out, codec_out_data,
             proc_in_valid, proc_in_data, proc_out_ready
   );
   modport slave (
      output audio_in_available, codec_in_data, audio_out_allowed,
             proc_in_ready, proc_out_valid, proc_out_data,
      input  read_audio_in, write_audio_out, codec_out_data,
             proc_in_valid, proc_in_data, proc_out_ready
   );
endinterface

// File: rtl/audio_stream_bridge.sv
// audio_stream_bridge: codec FIFO to effects-core bridge with capture stage, output frame FIFO and statistics
module audio_stream_bridge #(
   parameter int SAMPLE_W     = 32,
   parameter int NUM_CH       = 2,
   parameter int DEPTH        = 8,
   parameter int HOLD_TIMEOUT = 1024,
   parameter int CNT_W        = 16
) (
   input  logic                       CLOCK_50,
   input  logic                       reset_n,
   input  logic [1:0]                 mode,
   audio_stream_bridge_if.master      bus,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level,
   output logic [CNT_W-1:0]           overrun_count,
   output logic [CNT_W-1:0]           underrun_count
);
   localparam int FW = SAMPLE_W * NUM_CH;
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(HOLD_TIMEOUT + 1);
   localparam logic [1:0] IN_IDLE   = 2'd0;
   localparam logic [1:0] IN_READ   = 2'd1;
   localparam logic [1:0] IN_HOLD   = 2'd2;
   localparam logic [1:0] OUT_IDLE  = 2'd0;
   localparam logic [1:0] OUT_WRITE = 2'd1;
   localparam logic [1:0] OUT_GAP   = 2'd2;
   localparam logic [1:0] M_BYPASS  = 2'b01;
   localparam logic [1:0] M_MUTE    = 2'b10;

   logic [1:0]    in_state, out_state, mode_q;
   logic [FW-1:0] hold_reg, out_reg;
   logic [FW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [TW-1:0] hold_cnt;
   logic          starve_q;
   logic          process, full, empty, in_xfer, hold_push, push, pop, timeout, starve;

   assign process   = mode_q != M_BYPASS && mode_q != M_MUTE;
   assign full      = fifo_level == LW'(DEPTH);
   assign empty     = fifo_level == '0;
   assign in_xfer   = in_state == IN_HOLD && process && bus.proc_in_ready;
   assign hold_push = in_state == IN_HOLD && !process && !full;
   assign push      = hold_push || (bus.proc_out_valid && bus.proc_out_ready);
   assign pop       = out_state == OUT_WRITE;
   assign timeout   = in_state == IN_HOLD && !in_xfer && !hold_push && hold_cnt == TW'(HOLD_TIMEOUT - 1);
   assign starve    = bus.audio_out_allowed && empty;

   assign bus.read_audio_in   = in_state == IN_READ;
   assign bus.proc_in_valid   = in_state == IN_HOLD && process;
   assign bus.proc_in_data    = hold_reg;
   assign bus.proc_out_ready  = !full && process;
   assign bus.write_audio_out = out_state == OUT_WRITE;
   assign bus.codec_out_data  = out_reg;

   // mode_q tracks mode on every idle cycle so a frame is handled with the mode seen when it arrived
   always_ff @(posedge CLOCK_50 or negedge reset_n)
      if (!reset_n) begin
         in_state      <= IN_IDLE;
         mode_q        <= 2'b00;
         hold_reg      <= '0;
         hold_cnt      <= '0;
         overrun_count <= '0;
      end else begin
         case (in_state)
            IN_IDLE: begin
               mode_q <= mode;
               if (bus.audio_in_available) in_state <= IN_READ;
            end
            IN_READ: begin
               hold_reg <= mode_q == M_MUTE ? '0 : bus.codec_in_data;
               hold_cnt <= '0;
               in_state <= IN_HOLD;
            end
            IN_HOLD: begin
               hold_cnt <= hold_cnt + TW'(1);
               if (in_xfer || hold_push || timeout) in_state <= IN_IDLE;
            end
            default: in_state <= IN_IDLE;
         endcase
         if (timeout && overrun_count != '1) overrun_count <= overrun_count + CNT_W'(1);
      end

   always_ff @(posedge CLOCK_50)
      if (push) mem[wr_ptr] <= hold_push ? hold_reg : bus.proc_out_data;

   always_ff @(posedge CLOCK_50 or negedge reset_n)
      if (!reset_n) begin
         out_state      <= OUT_IDLE;
         out_reg        <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_level     <= '0;
         starve_q       <= 1'b0;
         underrun_count <= '0;
      end else begin
         wr_ptr     <= wr_ptr + AW'(push);
         rd_ptr     <= rd_ptr + AW'(pop);
         fifo_level <= fifo_level + LW'(push) - LW'(pop);
         case (out_state)
            OUT_IDLE: if (bus.audio_out_allowed && !empty) begin
               out_state <= OUT_WRITE;
               out_reg   <= mem[rd_ptr];
            end
            OUT_WRITE: out_state <= OUT_GAP;
            default:   out_state <= OUT_IDLE;
         endcase
         starve_q <= starve;
         if (starve && !starve_q && underrun_count != '1) underrun_count <= underrun_count + CNT_W'(1);
      end
endmodule

// File: tb/tb_audio_stream_bridge.sv
// tb_audio_stream_bridge: codec/effects-core environment with a frame scoreboard for audio_stream_bridge
module tb_audio_stream_bridge;
   localparam int SW = 32;
   localparam int NC = 2;
   localparam int FW = SW * NC;
   localparam int DEPTH = 8;
   localparam int HT = 64;
   localparam int CW = 16;

   logic clk = 0;
   logic reset_n = 0;
   logic [1:0] mode = 2'b00;
   logic [$clog2(DEPTH+1)-1:0] fifo_level;
   logic [CW-1:0] overrun_count, underrun_count;
   audio_stream_bridge_if #(.SAMPLE_W(SW), .NUM_CH(NC)) bus();

   audio_stream_bridge #(.SAMPLE_W(SW), .NUM_CH(NC), .DEPTH(DEPTH), .HOLD_TIMEOUT(HT), .CNT_W(CW)) dut (
      .CLOCK_50(clk), .reset_n(reset_n), .mode(mode), .bus(bus),
      .fifo_level(fifo_level), .overrun_count(overrun_count), .underrun_count(underrun_count)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [FW-1:0] in_q[$], got_q[$], exp_q[$], core_q[$];
   bit rd_s, pout_s, rand_en, core_stall, pin_seen, prev_pending;
   int core_delay, vcnt, stab_err;
   logic [FW-1:0] prev_data;

   typedef struct {
      logic [1:0]    m;
      logic [FW-1:0] din;
      logic [FW-1:0] dout;
   } vec_t;
   vec_t vt[6];

   function automatic logic [FW-1:0] plus1(input logic [FW-1:0] f);
      logic [FW-1:0] r;
      for (int c = 0; c < NC; c++) r[c*SW +: SW] = f[c*SW +: SW] + SW'(1);
      return r;
   endfunction

   function automatic logic [FW-1:0] exp_of(input logic [1:0] m, input logic [FW-1:0] f);
      return m == 2'b01 ? f : m == 2'b10 ? '0 : plus1(f);
   endfunction

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Sample DUT outputs mid-cycle; the codec controller pops and the core answers after the next edge
   always @(negedge clk) if (reset_n) begin
      rd_s = bus.read_audio_in;
      pout_s = bus.proc_out_valid && bus.proc_out_ready;
      if (bus.write_audio_out) got_q.push_back(bus.codec_out_data);
      if (bus.proc_in_valid) pin_seen = 1;
      if (prev_pending && (!bus.proc_in_valid || bus.proc_in_data !== prev_data)) stab_err++;
      prev_pending = bus.proc_in_valid && !bus.proc_in_ready;
      prev_data = bus.proc_in_data;
      if (bus.proc_in_valid && bus.proc_in_ready) core_q.push_back(plus1(bus.proc_in_data));
      vcnt = prev_pending ? vcnt + 1 : 0;
   end

   always @(posedge clk) begin
      #1;
      if (rd_s && in_q.size() > 0) void'(in_q.pop_front());
      if (pout_s && core_q.size() > 0) void'(core_q.pop_front());
      rd_s = 0;
      pout_s = 0;
      bus.audio_in_available = in_q.size() > 0;
      bus.codec_in_data = in_q.size() > 0 ? in_q[0] : '0;
      bus.proc_in_ready = !core_stall && vcnt >= core_delay;
      bus.proc_out_valid = core_q.size() > 0;
      bus.proc_out_data = core_q.size() > 0 ? core_q[0] : '0;
      if (rand_en) bus.audio_out_allowed = $urandom_range(0, 3) != 0;
   end

   task automatic send(input logic [FW-1:0] f, input logic [FW-1:0] e, input bit ex);
      in_q.push_back(f);
      if (ex) exp_q.push_back(e);
      bus.audio_in_available = 1;
      bus.codec_in_data = in_q[0];
   endtask

   task automatic clear_env();
      in_q.delete(); core_q.delete(); got_q.delete(); exp_q.delete();
      rd_s = 0; pout_s = 0; vcnt = 0; prev_pending = 0;
      bus.audio_in_available = 0;
      bus.codec_in_data = '0;
      bus.proc_out_valid = 0;
      bus.proc_out_data = '0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset_n = 0;
      clear_env();
      repeat (2) @(negedge clk);
      reset_n = 1;
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int n;
      for (int i = 0; i < budget && got_q.size() < exp_q.size(); i++) @(negedge clk);
      repeat (6) @(negedge clk);
      chk("frame_count", FW'(got_q.size()), FW'(exp_q.size()));
      n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk("frame_data", got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [FW-1:0] f;
      int m, n;
      vt[0] = '{2'b01, 64'hFFFF8000_00001234, 64'hFFFF8000_00001234};
      vt[1] = '{2'b10, 64'hDEADBEEF_CAFEF00D, 64'h0};
      vt[2] = '{2'b00, 64'h00000001_00000002, 64'h00000002_00000003};
      vt[3] = '{2'b00, 64'hFFFFFFFF_7FFFFFFF, 64'h00000000_80000000};
      vt[4] = '{2'b11, 64'h12345678_FFFFFFFF, 64'h12345679_00000000};
      vt[5] = '{2'b01, 64'h0, 64'h0};
      bus.audio_out_allowed = 0;
      bus.proc_in_ready = 0;
      clear_env();
      core_delay = 0;
      repeat (3) @(negedge clk);
      chk("reset_read", FW'(bus.read_audio_in), 0);
      chk("reset_write", FW'(bus.write_audio_out), 0);
      chk("reset_codec_out", bus.codec_out_data, 0);
      reset_n = 1;
      repeat (2) @(negedge clk);
      chk("reset_level", FW'(fifo_level), 0);
      chk("reset_counters", FW'({overrun_count, underrun_count}), 0);
      chk("reset_proc_in_valid", FW'(bus.proc_in_valid), 0);
      chk("reset_mode_process", FW'(bus.proc_out_ready), 1);

      // bypass latency: available at cycle 0, read at 1, write at 4
      mode = 2'b01;
      bus.audio_out_allowed = 1;
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
      send(64'hFFFF8000_00001234, '0, 0);
      @(negedge clk); chk("lat_c0_read", FW'(bus.read_audio_in), 0);
      @(negedge clk); chk("lat_c1_read", FW'(bus.read_audio_in), 1);
      @(negedge clk); chk("lat_c2_read", FW'(bus.read_audio_in), 0);
      @(negedge clk); chk("lat_c3_level", FW'(fifo_level), 1);
      chk("lat_c3_write", FW'(bus.write_audio_out), 0);
      @(negedge clk); chk("lat_c4_write", FW'(bus.write_audio_out), 1);
      chk("lat_c4_data", bus.codec_out_data, 64'hFFFF8000_00001234);
      @(negedge clk); chk("lat_c5_level", FW'(fifo_level), 0);
      got_q.delete();

      for (int i = 0; i < 6; i++) begin
         mode = vt[i].m;
         @(negedge clk);
         send(vt[i].din, vt[i].dout, 1);
         drain(100);
      end

      mode = 2'b10;
      pin_seen = 0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) send({$urandom, $urandom}, '0, 1);
      drain(100);
      chk("mute_no_proc_valid", FW'(pin_seen), 0);

      mode = 2'b00;
      core_delay = 2;
      stab_err = 0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         f = {$urandom, $urandom};
         send(f, plus1(f), 1);
      end
      drain(200);
      chk("proc_valid_stable", FW'(stab_err), 0);

      rand_en = 1;
      for (int b = 0; b < 10; b++) begin
         m = $urandom_range(0, 3);
         n = $urandom_range(1, 6);
         mode = 2'(m);
         core_delay = $urandom_range(0, 3);
         @(negedge clk);
         for (int i = 0; i < n; i++) begin
            f = {$urandom, $urandom};
            send(f, exp_of(2'(m), f), 1);
         end
         drain(600);
      end
      rand_en = 0;
      core_delay = 0;
      chk("random_no_overrun", FW'(overrun_count), 0);

      // overflow: 8 frames fill the FIFO, the 9th times out, the 10th is pushed once drain starts
      mode = 2'b01;
      bus.audio_out_allowed = 0;
      @(negedge clk);
      for (int i = 1; i <= 10; i++) send(FW'(i), FW'(i), i != 9);
      repeat (40) @(negedge clk);
      chk("ovf_level_full", FW'(fifo_level), 8);
      chk("ovf_not_yet", FW'(overrun_count), 0);
      for (int i = 0; i < 200 && overrun_count == 0; i++) @(negedge clk);
      chk("ovf_overrun", FW'(overrun_count), 1);
      chk("ovf_level_still_full", FW'(fifo_level), 8);
      bus.audio_out_allowed = 1;
      drain(200);
      chk("ovf_overrun_after", FW'(overrun_count), 1);

      // reset while a frame is held and three frames are queued
      mode = 2'b00;
      bus.audio_out_allowed = 0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) send({$urandom, $urandom}, '0, 0);
      for (int i = 0; i < 100 && fifo_level != 3; i++) @(negedge clk);
      core_stall = 1;
      send(64'hAAAA5555_12121212, '0, 0);
      for (int i = 0; i < 20 && !bus.proc_in_valid; i++) @(negedge clk);
      chk("rst_pre_level", FW'(fifo_level), 3);
      chk("rst_pre_hold", FW'(bus.proc_in_valid), 1);
      #2 reset_n = 0;
      #1;
      chk("rst_level", FW'(fifo_level), 0);
      chk("rst_proc_in", FW'({bus.proc_in_valid, bus.proc_in_data}), 0);
      chk("rst_codec_out", FW'({bus.write_audio_out, bus.read_audio_in}), 0);
      chk("rst_codec_data", bus.codec_out_data, 0);
      chk("rst_counters", FW'({overrun_count, underrun_count}), 0);
      clear_env();
      core_stall = 0;
      repeat (2) @(negedge clk);
      reset_n = 1;
      mode = 2'b01;
      bus.audio_out_allowed = 1;
      @(negedge clk);
      send(64'h0BADF00D_00C0FFEE, 64'h0BADF00D_00C0FFEE, 1);
      drain(100);

      // underrun episodes
      bus.audio_out_allowed = 0;
      pulse_reset();
      chk("und_start", FW'(underrun_count), 0);
      bus.audio_out_allowed = 1;
      repeat (50) @(negedge clk);
      chk("und_one", FW'(underrun_count), 1);
      send(64'h11112222_33334444, 64'h11112222_33334444, 1);
      drain(100);
      chk("und_two", FW'(underrun_count), 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
